mc_control: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder.
- Moore-style FSM that sequences fetch, decode, execute, memory and write-back over several clocks and drives the shared-ALU datapath strobes.
- Supports R-type, lw, sw, beq, j and addi, with a mem_ready wait handshake on every memory access.
- Flags unsupported opcodes and pulses on instruction completion for the perf counter.

---
 rtl/mc_control_if.sv | 38 +++
 rtl/mc_control.sv | 157 +++++++++++++++
 tb/tb_mc_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle controller and the shared-ALU datapath.
// master = controller (drives strobes), slave = datapath/instruction side.
interface mc_control_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] op_code;
    logic            mem_ready;
    logic            PCWrite;
    logic            PCWriteCond;
    logic            IorD;
    logic            MemRead;
    logic            MemWrite;
    logic            IRWrite;
    logic            MemtoReg;
    logic            RegDst;
    logic            RegWrite;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic [1:0]      PCSource;
    logic [3:0]      state;
    logic            illegal_op;
    logic            instr_done;

    modport master (
        input  op_code, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, illegal_op, instr_done
    );

    modport slave (
        output op_code, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, illegal_op, instr_done
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle main controller: Moore FSM sequencing fetch/decode/execute/
// memory/write-back and driving the shared-ALU datapath strobes.
module mc_control #(
    parameter int OP_W     = 6,
    parameter int OP_RTYPE = 0,
    parameter int OP_LW    = 35,
    parameter int OP_SW    = 43,
    parameter int OP_BEQ   = 4,
    parameter int OP_J     = 2,
    parameter int OP_ADDI  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    state_e state_q, state_d;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, done;
    logic [1:0] alu_src_b, alu_op, pc_source;

    logic [OP_W-1:0] op;
    assign op = bus.op_code;

    // State register; reset returns to FETCH and abandons any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_d = S_MEMADR;
                else if (op == OP_W'(OP_RTYPE))               state_d = S_EXEC;
                else if (op == OP_W'(OP_BEQ))                 state_d = S_BRANCH;
                else if (op == OP_W'(OP_J))                   state_d = S_JUMP;
                else if (op == OP_W'(OP_ADDI))                state_d = S_ADDIEX;
                else                                          state_d = S_FETCH;
            end
            S_MEMADR: state_d = (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RCOMP;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH; // completion states and unused codes
        endcase
    end

    // Output decode from state (plus mem_ready in wait states); forced low in reset.
    always_comb begin
        pc_write = 1'b0; pc_write_cond = 1'b0; iord = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; ir_write = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
        reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; alu_op = 2'b00;
        pc_source = 2'b00; illegal = 1'b0; done = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    if (!(op == OP_W'(OP_LW) || op == OP_W'(OP_SW) ||
                          op == OP_W'(OP_RTYPE) || op == OP_W'(OP_BEQ) ||
                          op == OP_W'(OP_J) || op == OP_W'(OP_ADDI))) begin
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    done       = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    done      = bus.mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RCOMP: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    done      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    done          = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    done      = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    done      = 1'b1;
                end
                default: ; // unused codes: all strobes stay low
            endcase
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.state       = state_q;
    assign bus.illegal_op  = illegal;
    assign bus.instr_done  = done;

endmodule

// File: tb/tb_mc_control.sv
// Directed vector bench for mc_control: per-cycle table of inputs and
// hand-computed state/strobe expectations, plus latency and async-reset sequences.
module tb_mc_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_if #(.OP_W(6)) bus ();

    mc_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Expected-output bit positions (18 bits of strobes)
    localparam logic [17:0] PCW  = 18'h20000, PCWC = 18'h10000, IORD = 18'h08000,
                            MRD  = 18'h04000, MWR  = 18'h02000, IRW  = 18'h01000,
                            M2R  = 18'h00800, RDST = 18'h00400, RWR  = 18'h00200,
                            SRCA = 18'h00100, ILL  = 18'h00002, DONE = 18'h00001;

    function automatic logic [17:0] srcb(input logic [1:0] v); return {10'd0, v, 6'd0}; endfunction
    function automatic logic [17:0] aluop(input logic [1:0] v); return {12'd0, v, 4'd0}; endfunction
    function automatic logic [17:0] pcsrc(input logic [1:0] v); return {14'd0, v, 2'd0}; endfunction

    typedef struct packed {
        logic        rst_n;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [17:0] outs();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op, bus.instr_done};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [17:0] e);
        vec_t v;
        v.rst_n = r; v.op = op; v.mr = mr; v.st = st; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d outs=%05h, want state=%0d outs=%05h",
                     name, got[21:18], got[17:0], exp[21:18], exp[17:0]);
        end
    endtask

    initial begin
        logic [17:0] F_W, F_R;
        int cyc;
        F_W = MRD | srcb(2'b01);
        F_R = PCW | MRD | IRW | srcb(2'b01);

        bus.op_code   = 6'd0;
        bus.mem_ready = 1'b0;

        // reset held
        add(0, 0, 1, 0, '0);
        // R-type, mem_ready toggled where ignored
        add(1, 0, 1, 0, F_R);
        add(1, 0, 0, 1, srcb(2'b11));
        add(1, 0, 0, 6, SRCA | aluop(2'b10));
        add(1, 0, 0, 7, RWR | RDST | DONE);
        // lw: 2 fetch waits, 3 memrd waits -> 10 cycles
        add(1, 35, 0, 0, F_W);
        add(1, 35, 0, 0, F_W);
        add(1, 35, 1, 0, F_R);
        add(1, 35, 1, 1, srcb(2'b11));
        add(1, 35, 1, 2, SRCA | srcb(2'b10));
        add(1, 35, 0, 3, MRD | IORD);
        add(1, 35, 0, 3, MRD | IORD);
        add(1, 35, 0, 3, MRD | IORD);
        add(1, 35, 1, 3, MRD | IORD);
        add(1, 35, 0, 4, RWR | M2R | DONE);
        // sw with one MEMWR wait
        add(1, 43, 1, 0, F_R);
        add(1, 43, 1, 1, srcb(2'b11));
        add(1, 43, 1, 2, SRCA | srcb(2'b10));
        add(1, 43, 0, 5, MWR | IORD);
        add(1, 43, 1, 5, MWR | IORD | DONE);
        // beq
        add(1, 4, 1, 0, F_R);
        add(1, 4, 1, 1, srcb(2'b11));
        add(1, 4, 1, 8, SRCA | aluop(2'b01) | PCWC | pcsrc(2'b01) | DONE);
        // j
        add(1, 2, 1, 0, F_R);
        add(1, 2, 1, 1, srcb(2'b11));
        add(1, 2, 0, 9, PCW | pcsrc(2'b10) | DONE);
        // addi
        add(1, 8, 1, 0, F_R);
        add(1, 8, 1, 1, srcb(2'b11));
        add(1, 8, 1, 10, SRCA | srcb(2'b10));
        add(1, 8, 1, 11, RWR | DONE);
        // illegal opcode, then back in FETCH with no write strobes
        add(1, 63, 1, 0, F_R);
        add(1, 63, 1, 1, srcb(2'b11) | ILL | DONE);
        add(1, 63, 0, 0, F_W);
        // reset during MEMWR wait
        add(1, 43, 1, 0, F_R);
        add(1, 43, 1, 1, srcb(2'b11));
        add(1, 43, 1, 2, SRCA | srcb(2'b10));
        add(1, 43, 0, 5, MWR | IORD);
        add(0, 43, 0, 0, '0);
        add(1, 43, 0, 0, F_W);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            bus.op_code   = vecs[i].op;
            bus.mem_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), {bus.state, outs()}, {vecs[i].st, vecs[i].exp});
        end

        // zero-wait lw latency from FETCH entry (currently in FETCH)
        @(negedge clk);
        bus.op_code = 6'd35; bus.mem_ready = 1'b1;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            cyc++;
            if (bus.instr_done) break;
            @(negedge clk);
        end
        check("lw_latency", 22'(cyc), 22'd5);

        // async reset asserted between edges while MEMWR is waiting
        @(negedge clk); bus.op_code = 6'd43; bus.mem_ready = 1'b1; // FETCH
        @(negedge clk);                                           // DECODE
        @(negedge clk);                                           // MEMADR
        @(negedge clk); bus.mem_ready = 1'b0; #1;                 // MEMWR
        check("memwr_before_rst", {bus.state, outs()}, {4'd5, MWR | IORD});
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("async_rst_mid", {bus.state, outs()}, {4'd0, 18'd0});
        @(negedge clk); rst_n = 1'b1; #1;
        check("after_release", {bus.state, outs()}, {4'd0, F_W});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
